beep_sched: RTL and testbench
=============================

// Module: beep_sched
// PURPOSE
//  Arbitrates the count-game beeper among three event sources: key click, round end and game over.
//  Each granted request plays a fixed tone/silence pattern on the single beep pin.
//  Sits between the game FSM (pulsed requests) and the buzzer output, replacing ad-hoc per-event beep logic.
//  Sticky pending bits with fixed priority; game-over pre-empts any pattern in progress.
// PARAMETERS
//  TICKS_PER_MS  1    clk cycles per ms (clk = 1 kHz)
//  CLICK_MS      100  ID0 pattern: HI tone, single segment
//  ROUND_MS      200  ID1 pattern: HI ROUND_MS, gap GAP_MS, HI ROUND_MS
//  GAP_MS        100  silent segment length inside ID1
//  OVER_MS       500  ID2 pattern: HI OVER_MS then LO OVER_MS
// PORTS
//  clk    in   1  system clock, rising edge
//  rst    in   1  synchronous reset, active-high
//  req    in   3  one-cycle request pulses; bit i = pattern ID i (0 click, 1 round, 2 over)
//  beep   out  1  buzzer drive
//  busy   out  1  a pattern is playing
//  grant  out  2  ID of active pattern; 2'd3 when idle
//  done   out  1  one-cycle pulse: pattern completed normally
//  abort  out  1  one-cycle pulse: pattern pre-empted by ID2
// BEHAVIOUR
//  Reset (rst=1 at edge): beep=0, busy=0, grant=3, done=0, abort=0, pending=0, FSM=IDLE.
//   Reset mid-pattern drops everything, including pending requests.
//  Pending: req[i]=1 at edge k sets pend[i] at k; duplicate requests merge into one bit.
//   A request for the currently playing ID sets pend again, so the pattern replays once more afterwards.
//  FSM states IDLE, PLAY, DONE.
//   IDLE: if pend != 0, grant highest set bit (2>1>0), clear it, seg=0, cnt=0 -> PLAY.
//    Gives 1-cycle latency: req at edge k, busy=1 after edge k+1.
//   PLAY: cnt counts 0..len(seg)-1.
//    At the last count: advance seg with cnt=0, or on the last segment -> DONE.
//   DONE: done=1, busy=0, grant=3 for one cycle -> IDLE. No grant is issued in DONE.
//  Pre-emption: in PLAY with grant!=2 and pend[2]=1 at an edge, that edge does the following.
//   Aborts the current pattern: no done, abort=1 for one cycle, aborted ID not re-pended.
//   Loads ID2 seg0 directly: busy stays 1, grant=2.
//   ID2 is never pre-empted, including by a new req[2].
//  Segment lengths = ms * TICKS_PER_MS.
//   Counter width = $clog2(OVER_MS*TICKS_PER_MS).
//   Parameters must satisfy ms*TICKS_PER_MS >= 2.
//  Tone generator (phase reset to beep=0 at every segment start):
//   HI: beep toggles every cycle (clk/2).
//   LO: beep toggles every 2 cycles (clk/4).
//   GAP: beep=0.
//  beep=0 whenever busy=0.
//  Total busy cycles: ID0=100, ID1=500, ID2=1000 at default parameters.
// STRUCTURE
//  Package beep_pkg: ID localparams (ID_CLICK=0, ID_ROUND=1, ID_OVER=2, ID_NONE=3).
//   Tone enum (TONE_GAP, TONE_HI, TONE_LO).
//   Function seg_info(id, seg) -> {tone, len, last}.
//  Sub-module beep_tone_gen: inputs clk, rst, restart, tone; output beep.
//   Holds the divider and phase. Restart is pulsed by beep_sched on every segment load.
//  beep_sched keeps pend, arbiter, FSM, seg/cnt counters.
// TESTING
//  1. req=3'b001 at cycle 10 -> busy rises after cycle 11, grant=0.
//     beep toggles each cycle for 100 cycles, then done pulse, grant=3.
//  2. req=3'b011 same cycle -> ID1 plays first: HI 200, beep=0 for 100, HI 200, done.
//     Then ID0 plays after a one-cycle DONE gap plus the IDLE grant.
//  3. ID1 running, req[2] at cycle 150 of pattern -> abort pulse at next edge.
//     grant=2 without busy dropping, ID2 runs 1000 cycles.
//     LO half toggles every 2 cycles, then done. ID1 does not replay.
//  4. ID2 running, req[2] and req[0] pulsed -> no abort.
//     After done, ID2 replays (priority), then ID0.
//  5. rst=1 for one cycle mid-ID1 with pend[0] set -> next cycle beep=0, busy=0, grant=3.
//     No done or abort pulses, and nothing plays afterwards.
//  6. req[1] pulsed three times during ID1 playback -> exactly one replay of ID1.

Source files
------------

// File: rtl/beep_pkg.sv
// Shared IDs, tone/state encodings and the per-pattern segment table for the beeper.
package beep_pkg;

    localparam logic [1:0] ID_CLICK = 2'd0;
    localparam logic [1:0] ID_ROUND = 2'd1;
    localparam logic [1:0] ID_OVER  = 2'd2;
    localparam logic [1:0] ID_NONE  = 2'd3;

    typedef enum logic [1:0] {TONE_GAP, TONE_HI, TONE_LO} tone_e;
    typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_DONE} state_e;

    typedef struct packed {
        tone_e       tone;
        logic [31:0] len;
        logic        last;
    } seg_t;

    function automatic seg_t seg_info(input logic [1:0]  id,
                                      input logic [1:0]  seg,
                                      input logic [31:0] click_len,
                                      input logic [31:0] round_len,
                                      input logic [31:0] gap_len,
                                      input logic [31:0] over_len);
        seg_t s;
        s.tone = TONE_GAP;
        s.len  = 32'd2;
        s.last = 1'b1;
        case (id)
            ID_CLICK: begin
                s.tone = TONE_HI;
                s.len  = click_len;
            end
            ID_ROUND: begin
                case (seg)
                    2'd0:    begin s.tone = TONE_HI;  s.len = round_len; s.last = 1'b0; end
                    2'd1:    begin s.tone = TONE_GAP; s.len = gap_len;   s.last = 1'b0; end
                    default: begin s.tone = TONE_HI;  s.len = round_len; s.last = 1'b1; end
                endcase
            end
            ID_OVER: begin
                if (seg == 2'd0) begin
                    s.tone = TONE_HI;
                    s.len  = over_len;
                    s.last = 1'b0;
                end else begin
                    s.tone = TONE_LO;
                    s.len  = over_len;
                end
            end
            default: ;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/beep_tone_gen.sv
// Square-wave tone generator: clk/2 for HI, clk/4 for LO, silent for GAP.
module beep_tone_gen
    import beep_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       restart,
    input  logic [1:0] tone,
    output logic       beep
);

    logic r_beep;
    logic r_div;

    // tone is the tone of the cycle being entered, so beep is already correct on it
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            r_beep <= 1'b0;
            r_div  <= 1'b0;
        end else begin
            case (tone_e'(tone))
                TONE_HI: begin
                    r_beep <= ~r_beep;
                    r_div  <= 1'b0;
                end
                TONE_LO: begin
                    r_div <= ~r_div;
                    if (r_div)
                        r_beep <= ~r_beep;
                end
                default: begin
                    r_beep <= 1'b0;
                    r_div  <= 1'b0;
                end
            endcase
        end
    end

    assign beep = r_beep;

endmodule

// File: rtl/beep_sched.sv
// Beeper arbiter: sticky pending requests, fixed priority 2>1>0, game-over pre-empts.
module beep_sched
    import beep_pkg::*;
#(
    parameter int unsigned TICKS_PER_MS = 1,
    parameter int unsigned CLICK_MS     = 100,
    parameter int unsigned ROUND_MS     = 200,
    parameter int unsigned GAP_MS       = 100,
    parameter int unsigned OVER_MS      = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    output logic       beep,
    output logic       busy,
    output logic [1:0] grant,
    output logic       done,
    output logic       abort
);

    localparam int unsigned CW = $clog2(OVER_MS * TICKS_PER_MS);
    localparam logic [31:0] L_CLICK = 32'(CLICK_MS * TICKS_PER_MS);
    localparam logic [31:0] L_ROUND = 32'(ROUND_MS * TICKS_PER_MS);
    localparam logic [31:0] L_GAP   = 32'(GAP_MS * TICKS_PER_MS);
    localparam logic [31:0] L_OVER  = 32'(OVER_MS * TICKS_PER_MS);

    state_e        r_state;
    logic [2:0]    r_pend;
    logic [1:0]    r_grant;
    logic [1:0]    r_seg;
    logic [CW-1:0] r_cnt;
    logic          r_abort;

    state_e        w_state_nxt;
    logic [1:0]    w_grant_nxt;
    logic [1:0]    w_seg_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]    w_clr;
    logic          w_abort_nxt;
    logic          w_restart;
    logic [1:0]    w_arb_id;
    seg_t          w_cur;
    seg_t          w_nxt;
    tone_e         w_tone;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_seg_nxt   = r_seg;
        w_cnt_nxt   = r_cnt;
        w_clr       = '0;
        w_abort_nxt = 1'b0;
        w_restart   = 1'b0;
        w_arb_id    = r_pend[2] ? ID_OVER : (r_pend[1] ? ID_ROUND : ID_CLICK);
        w_cur       = seg_info(r_grant, r_seg, L_CLICK, L_ROUND, L_GAP, L_OVER);

        case (r_state)
            ST_IDLE: begin
                if (r_pend != 3'b000) begin
                    w_grant_nxt           = w_arb_id;
                    w_clr[w_arb_id]       = 1'b1;
                    w_seg_nxt             = '0;
                    w_cnt_nxt             = '0;
                    w_restart             = 1'b1;
                    w_state_nxt           = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (r_grant != ID_OVER && r_pend[2]) begin
                    w_abort_nxt = 1'b1;
                    w_grant_nxt = ID_OVER;
                    w_clr       = 3'b100;
                    w_seg_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_restart   = 1'b1;
                end else if (32'(r_cnt) == w_cur.len - 32'd1) begin
                    if (w_cur.last) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_seg_nxt = r_seg + 2'd1;
                        w_cnt_nxt = '0;
                        w_restart = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // tone generator is driven with the upcoming segment's tone
        w_nxt  = seg_info(w_grant_nxt, w_seg_nxt, L_CLICK, L_ROUND, L_GAP, L_OVER);
        w_tone = (w_state_nxt == ST_PLAY) ? w_nxt.tone : TONE_GAP;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pend  <= '0;
            r_grant <= ID_NONE;
            r_seg   <= '0;
            r_cnt   <= '0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= (r_pend & ~w_clr) | req;
            r_grant <= w_grant_nxt;
            r_seg   <= w_seg_nxt;
            r_cnt   <= w_cnt_nxt;
            r_abort <= w_abort_nxt;
        end
    end

    beep_tone_gen u_tone (
        .clk     (clk),
        .rst     (rst),
        .restart (w_restart),
        .tone    (w_tone),
        .beep    (beep)
    );

    assign busy  = (r_state == ST_PLAY);
    assign grant = (r_state == ST_PLAY) ? r_grant : ID_NONE;
    assign done  = (r_state == ST_DONE);
    assign abort = r_abort;

endmodule

// File: tb/tb_beep_sched.sv
// Directed bench for beep_sched with a pattern-level reference model checked every cycle.
module tb_beep_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic       beep;
    logic       busy;
    logic [1:0] grant;
    logic       done;
    logic       abort;

    int n_tests = 0;
    int n_fail  = 0;
    int n_busy, n_done, n_abort;

    // model state: mode 0 idle, 1 play, 2 done; t = cycle index within the pattern
    int       m_mode = 0;
    int       m_id   = 3;
    int       m_t    = 0;
    bit [2:0] m_pend = '0;
    bit       m_abort = 1'b0;
    bit       started = 1'b0;

    always #5 clk = ~clk;

    beep_sched #(
        .TICKS_PER_MS (1),
        .CLICK_MS     (100),
        .ROUND_MS     (200),
        .GAP_MS       (100),
        .OVER_MS      (500)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .beep  (beep),
        .busy  (busy),
        .grant (grant),
        .done  (done),
        .abort (abort)
    );

    function automatic int total(input int id);
        case (id)
            0:       return 100;
            1:       return 500;
            default: return 1000;
        endcase
    endfunction

    function automatic bit beep_at(input int id, input int t);
        case (id)
            0: return bit'(t % 2);
            1: begin
                if (t < 200) return bit'(t % 2);
                if (t < 300) return 1'b0;
                return bit'((t - 300) % 2);
            end
            default: begin
                if (t < 500) return bit'(t % 2);
                return bit'(((t - 500) / 2) % 2);
            end
        endcase
    endfunction

    always @(posedge clk) begin
        bit [2:0] p;
        p       = m_pend;
        m_abort = 1'b0;
        started = 1'b1;
        if (rst) begin
            m_mode = 0;
            m_id   = 3;
            m_t    = 0;
            m_pend = '0;
        end else begin
            case (m_mode)
                0: if (p != 3'b000) begin
                    m_id    = p[2] ? 2 : (p[1] ? 1 : 0);
                    p[m_id] = 1'b0;
                    m_mode  = 1;
                    m_t     = 0;
                end
                1: begin
                    if (m_id != 2 && p[2]) begin
                        m_abort = 1'b1;
                        m_id    = 2;
                        p[2]    = 1'b0;
                        m_t     = 0;
                    end else if (m_t == total(m_id) - 1) begin
                        m_mode = 2;
                    end else begin
                        m_t = m_t + 1;
                    end
                end
                default: m_mode = 0;
            endcase
            m_pend = p | req;
        end
    end

    always @(posedge clk) begin
        logic [5:0] exp_v;
        logic [5:0] act_v;
        #1;
        if (started) begin
            exp_v[5]   = (m_mode == 1) ? beep_at(m_id, m_t) : 1'b0;
            exp_v[4]   = (m_mode == 1);
            exp_v[3:2] = (m_mode == 1) ? 2'(m_id) : 2'd3;
            exp_v[1]   = (m_mode == 2);
            exp_v[0]   = m_abort;
            act_v      = {beep, busy, grant, done, abort};
            n_tests++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL outputs @%0t {beep,busy,grant,done,abort}: got %b, expected %b",
                         $time, act_v, exp_v);
            end
            if (busy  === 1'b1) n_busy++;
            if (done  === 1'b1) n_done++;
            if (abort === 1'b1) n_abort++;
        end
    end

    task automatic check(input string name, input int act, input int exp_val);
        n_tests++;
        if (act !== exp_val) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_val);
        end
    endtask

    task automatic clear_counts();
        n_busy  = 0;
        n_done  = 0;
        n_abort = 0;
    endtask

    task automatic pulse(input logic [2:0] r);
        @(negedge clk);
        req = r;
        @(negedge clk);
        req = 3'b000;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_counts(input string tag, input int eb, input int ed, input int ea);
        check({tag, " busy cycles"}, n_busy, eb);
        check({tag, " done pulses"}, n_done, ed);
        check({tag, " abort pulses"}, n_abort, ea);
    endtask

    initial begin
        rst = 1'b1;
        req = 3'b000;
        clear_counts();
        wait_cycles(3);
        check("reset busy", int'(busy), 0);
        check("reset grant", int'(grant), 3);
        check("reset beep", int'(beep), 0);
        check("reset done/abort", int'({done, abort}), 0);
        rst = 1'b0;
        wait_cycles(6);

        // 1: single click
        clear_counts();
        pulse(3'b001);
        @(posedge clk); #1;
        check("click latency busy", int'(busy), 1);
        check("click grant", int'(grant), 0);
        check("click first beep", int'(beep), 0);
        wait_cycles(120);
        check_counts("click", 100, 1, 0);
        check("click idle grant", int'(grant), 3);

        // 2: round and click together, round first
        clear_counts();
        pulse(3'b011);
        @(posedge clk); #1;
        check("dual grant first", int'(grant), 1);
        wait_cycles(720);
        check_counts("dual", 600, 2, 0);

        // 3: game-over pre-empts round at pattern cycle 150
        clear_counts();
        pulse(3'b010);
        wait_cycles(149);
        pulse(3'b100);
        @(posedge clk); #1;
        check("preempt abort", int'(abort), 1);
        check("preempt grant", int'(grant), 2);
        check("preempt busy", int'(busy), 1);
        wait_cycles(1100);
        check_counts("preempt", 1151, 1, 1);

        // 4: over not pre-empted; replays, then click
        clear_counts();
        pulse(3'b100);
        wait_cycles(10);
        pulse(3'b101);
        wait_cycles(2300);
        check_counts("over replay", 2100, 3, 0);

        // 5: reset mid-round with click pending
        clear_counts();
        pulse(3'b010);
        wait_cycles(50);
        pulse(3'b001);
        wait_cycles(50);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midreset busy", int'(busy), 0);
        check("midreset grant", int'(grant), 3);
        check("midreset beep", int'(beep), 0);
        @(negedge clk);
        rst = 1'b0;
        clear_counts();
        wait_cycles(300);
        check_counts("after reset", 0, 0, 0);

        // 6: repeated round requests merge into one replay
        clear_counts();
        pulse(3'b010);
        wait_cycles(20);
        pulse(3'b010);
        wait_cycles(20);
        pulse(3'b010);
        wait_cycles(20);
        pulse(3'b010);
        wait_cycles(1100);
        check_counts("merge", 1000, 2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
